// File: rtl/spec_peak_detect_if.sv
// Handshake bundle for the peak detector: sample stream in, frame result out.
// The master side drives samples and consumes results; the slave side is the detector.
interface spec_peak_detect_if #(
  parameter int WIDTH = 12,
  parameter int DEPTH = 8
);
  localparam int IW = $clog2(DEPTH);

  logic                  in_valid;
  logic                  in_ready;
  logic [WIDTH-1:0]      din;
  logic                  out_valid;
  logic                  out_ready;
  logic [WIDTH-1:0]      peak_val;
  logic [IW-1:0]         peak_idx;
  logic [WIDTH+IW-1:0]   frame_sum;
  logic                  alarm;

  modport master (
    output in_valid, din, out_ready,
    input  in_ready, out_valid, peak_val, peak_idx, frame_sum, alarm
  );

  modport slave (
    input  in_valid, din, out_ready,
    output in_ready, out_valid, peak_val, peak_idx, frame_sum, alarm
  );
endinterface

// File: rtl/spec_peak_detect.sv
// Frame peak detector: tracks max, its first index and the sum over DEPTH samples,
// then publishes them in a one-deep result register with a threshold alarm.
module spec_peak_detect #(
  parameter int               WIDTH  = 12,
  parameter int               DEPTH  = 8,
  parameter logic [WIDTH-1:0] THRESH = 'h800
) (
  input  logic             clk,
  input  logic             reset,
  spec_peak_detect_if.slave bus
);
  localparam int IW = $clog2(DEPTH);
  localparam int SW = WIDTH + IW;

  typedef enum logic {IDLE, SCAN} state_t;

  state_t            state_reg, state_next;
  logic [IW-1:0]     idx_reg, idx_next;
  logic [WIDTH-1:0]  max_reg, max_next;
  logic [IW-1:0]     max_idx_reg, max_idx_next;
  logic [SW-1:0]     sum_reg, sum_next;
  logic              out_valid_reg, out_valid_next;
  logic [WIDTH-1:0]  peak_val_reg, peak_val_next;
  logic [IW-1:0]     peak_idx_reg, peak_idx_next;
  logic [SW-1:0]     frame_sum_reg, frame_sum_next;
  logic              alarm_reg, alarm_next;

  logic              last_word;
  logic              ready;
  logic              accept;
  logic              consume;
  logic              take_new;
  logic [WIDTH-1:0]  cand_max;
  logic [IW-1:0]     cand_idx;
  logic [SW-1:0]     din_ext;
  logic [SW-1:0]     cand_sum;

  assign last_word = (idx_reg == IW'(DEPTH - 1));
  // Only the closing word needs the result register; earlier words keep flowing.
  assign ready     = !(last_word && out_valid_reg && !bus.out_ready);
  assign accept    = bus.in_valid && ready;
  assign consume   = out_valid_reg && bus.out_ready;

  // Strict compare so a tie keeps the earlier index.
  assign take_new  = (bus.din > max_reg);
  assign cand_max  = take_new ? bus.din : max_reg;
  assign cand_idx  = take_new ? idx_reg : max_idx_reg;
  assign din_ext   = {{IW{1'b0}}, bus.din};
  assign cand_sum  = sum_reg + din_ext;

  always_comb begin
    state_next     = state_reg;
    idx_next       = idx_reg;
    max_next       = max_reg;
    max_idx_next   = max_idx_reg;
    sum_next       = sum_reg;
    out_valid_next = out_valid_reg;
    peak_val_next  = peak_val_reg;
    peak_idx_next  = peak_idx_reg;
    frame_sum_next = frame_sum_reg;
    alarm_next     = alarm_reg;

    if (consume) begin
      out_valid_next = 1'b0;
    end

    if (accept) begin
      case (state_reg)
        IDLE: begin
          max_next     = bus.din;
          max_idx_next = '0;
          sum_next     = din_ext;
          idx_next     = IW'(1);
          state_next   = SCAN;
        end
        SCAN: begin
          max_next     = cand_max;
          max_idx_next = cand_idx;
          sum_next     = cand_sum;
          if (last_word) begin
            idx_next       = '0;
            state_next     = IDLE;
            out_valid_next = 1'b1;
            peak_val_next  = cand_max;
            peak_idx_next  = cand_idx;
            frame_sum_next = cand_sum;
            alarm_next     = (cand_max >= THRESH);
          end else begin
            idx_next = idx_reg + IW'(1);
          end
        end
        default: state_next = IDLE;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      state_reg     <= IDLE;
      idx_reg       <= '0;
      max_reg       <= '0;
      max_idx_reg   <= '0;
      sum_reg       <= '0;
      out_valid_reg <= 1'b0;
      peak_val_reg  <= '0;
      peak_idx_reg  <= '0;
      frame_sum_reg <= '0;
      alarm_reg     <= 1'b0;
    end else begin
      state_reg     <= state_next;
      idx_reg       <= idx_next;
      max_reg       <= max_next;
      max_idx_reg   <= max_idx_next;
      sum_reg       <= sum_next;
      out_valid_reg <= out_valid_next;
      peak_val_reg  <= peak_val_next;
      peak_idx_reg  <= peak_idx_next;
      frame_sum_reg <= frame_sum_next;
      alarm_reg     <= alarm_next;
    end
  end

  assign bus.in_ready  = ready;
  assign bus.out_valid = out_valid_reg;
  assign bus.peak_val  = peak_val_reg;
  assign bus.peak_idx  = peak_idx_reg;
  assign bus.frame_sum = frame_sum_reg;
  assign bus.alarm     = alarm_reg;
endmodule

// File: tb/tb_spec_peak_detect.sv
// Scoreboard bench for spec_peak_detect: a driver pushes reference results per frame,
// an independent monitor pops and compares on every consumed result.
module tb_spec_peak_detect;
  localparam int               W  = 12;
  localparam int               D  = 8;
  localparam int               IW = 3;
  localparam logic [W-1:0]     TH = 12'h800;

  typedef logic [W-1:0] frame_t [D];
  typedef struct {
    logic [W-1:0]    peak;
    logic [IW-1:0]   idx;
    logic [W+IW-1:0] sum;
    logic            alarm;
  } exp_t;

  logic clk = 1'b0;
  logic reset = 1'b0;

  spec_peak_detect_if #(.WIDTH(W), .DEPTH(D)) bus ();

  spec_peak_detect #(.WIDTH(W), .DEPTH(D), .THRESH(TH)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  int   compared   = 0;
  int   mismatched = 0;
  int   consumed   = 0;
  int   rdy_mode   = 0;
  logic force_rdy  = 1'b0;
  exp_t exp_q[$];

  // Reference: max first, then the lowest index holding that max.
  function automatic exp_t model(input frame_t f);
    exp_t e;
    e.peak = '0;
    e.sum  = '0;
    for (int i = 0; i < D; i++) begin
      if (f[i] > e.peak) e.peak = f[i];
      e.sum = e.sum + (W+IW)'(f[i]);
    end
    e.idx = '0;
    for (int i = D - 1; i >= 0; i--) begin
      if (f[i] == e.peak) e.idx = IW'(i);
    end
    e.alarm = (e.peak >= TH);
    return e;
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
    compared++;
    if (act !== req) begin
      mismatched++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, req);
    end
  endtask

  // out_ready driver, changes at +2 after each rising edge
  initial begin
    bus.out_ready = 1'b1;
    forever begin
      @(posedge clk);
      #2;
      case (rdy_mode)
        0:       bus.out_ready = 1'b1;
        1:       bus.out_ready = 1'($urandom_range(0, 1));
        default: bus.out_ready = force_rdy;
      endcase
    end
  end

  // Monitor: compares every consumed result and checks stability while stalled.
  initial begin
    exp_t e;
    logic hold_prev;
    logic [30:0] prev;
    hold_prev = 1'b0;
    prev = '0;
    forever begin
      @(negedge clk);
      if (!reset) begin
        hold_prev = 1'b0;
      end else begin
        if (hold_prev) begin
          chk("hold_valid", bus.out_valid, 1'b1);
          chk("hold_data", {bus.peak_val, bus.peak_idx, bus.frame_sum, bus.alarm}, prev);
        end
        if (bus.out_valid && bus.out_ready) begin
          consumed++;
          if (exp_q.size() == 0) begin
            compared++;
            mismatched++;
            $display("FAIL unexpected_result: got peak_val=0x%0h with no frame pending", bus.peak_val);
          end else begin
            e = exp_q.pop_front();
            $display("result %0d: peak_val=0x%0h peak_idx=%0d frame_sum=0x%0h alarm=%0d",
                     consumed, bus.peak_val, bus.peak_idx, bus.frame_sum, bus.alarm);
            chk("peak_val", bus.peak_val, e.peak);
            chk("peak_idx", bus.peak_idx, e.idx);
            chk("frame_sum", bus.frame_sum, e.sum);
            chk("alarm", bus.alarm, e.alarm);
          end
        end
        hold_prev = bus.out_valid && !bus.out_ready;
        prev = {bus.peak_val, bus.peak_idx, bus.frame_sum, bus.alarm};
      end
    end
  end

  // Called at posedge+1; returns at posedge+1 after the word is accepted.
  task automatic send_word(input logic [W-1:0] d, input int gap_pct);
    int  n;
    logic ok;
    if ($urandom_range(0, 99) < gap_pct) begin
      bus.in_valid = 1'b0;
      repeat ($urandom_range(1, 3)) @(posedge clk);
      #1;
    end
    bus.in_valid = 1'b1;
    bus.din = d;
    n = 0;
    do begin
      @(negedge clk);
      ok = bus.in_ready;
      n++;
    end while (!ok && n < 200);
    if (!ok) begin
      compared++;
      mismatched++;
      $display("FAIL accept_timeout: got in_ready=0 for %0d cycles, expected 1", n);
    end
    @(posedge clk);
    #1;
    bus.in_valid = 1'b0;
  endtask

  task automatic send_frame(input frame_t f, input int gap_pct);
    for (int i = 0; i < D; i++) send_word(f[i], gap_pct);
    exp_q.push_back(model(f));
    @(negedge clk);
    chk("latency_out_valid", bus.out_valid, 1'b1);
    @(posedge clk);
    #1;
  endtask

  task automatic drain();
    int n;
    n = 0;
    while (exp_q.size() != 0 && n < 200) begin
      @(posedge clk);
      #1;
      n++;
    end
    if (exp_q.size() != 0) begin
      compared++;
      mismatched++;
      $display("FAIL drain_timeout: got %0d results pending, expected 0", exp_q.size());
      exp_q.delete();
    end
  endtask

  task automatic check_reset_outputs(input string tag);
    chk({tag, "_out_valid"}, bus.out_valid, 1'b0);
    chk({tag, "_peak_val"}, bus.peak_val, '0);
    chk({tag, "_peak_idx"}, bus.peak_idx, '0);
    chk({tag, "_frame_sum"}, bus.frame_sum, '0);
    chk({tag, "_alarm"}, bus.alarm, 1'b0);
    chk({tag, "_in_ready"}, bus.in_ready, 1'b1);
  endtask

  function automatic logic [W-1:0] rand_sample(input int sel);
    case (sel)
      0:       return W'($urandom_range(0, 7));
      1:       return W'($urandom_range(0, 4095));
      2:       return W'($urandom_range(12'h7F0, 12'h810));
      default: return ($urandom_range(0, 1) != 0) ? 12'hFFF : 12'h000;
    endcase
  endfunction

  initial begin
    frame_t f, g;
    exp_t   eb;
    int     c0;
    bus.in_valid = 1'b0;
    bus.din = '0;

    repeat (3) @(posedge clk);
    @(negedge clk);
    check_reset_outputs("reset");
    @(posedge clk);
    #1;
    reset = 1'b1;
    @(negedge clk);
    chk("post_reset_in_ready", bus.in_ready, 1'b1);
    @(posedge clk);
    #1;

    // Directed frames
    f = '{12'd1, 12'd2, 12'd3, 12'd4, 12'd5, 12'd6, 12'd7, 12'd8};
    send_frame(f, 0);
    f = '{12'd5, 12'd9, 12'd3, 12'd9, 12'd0, 12'd9, 12'd1, 12'd2};
    send_frame(f, 0);
    for (int i = 0; i < D; i++) f[i] = 12'hFFF;
    send_frame(f, 0);
    f = '{12'h100, 12'h800, 12'h7FF, 12'h000, 12'h800, 12'h001, 12'h010, 12'h7FF};
    send_frame(f, 0);
    f = '{12'h7FF, 12'h100, 12'h7FE, 12'h000, 12'h7FF, 12'h001, 12'h010, 12'h200};
    send_frame(f, 0);

    // Gaps inside a ramp frame: exactly one result
    drain();
    c0 = consumed;
    f = '{12'd1, 12'd2, 12'd3, 12'd4, 12'd5, 12'd6, 12'd7, 12'd8};
    send_frame(f, 50);
    chk("gap_single_pulse", 32'(consumed - c0), 32'd1);

    // Backpressure across two back-to-back frames
    drain();
    rdy_mode = 2;
    force_rdy = 1'b0;
    @(posedge clk);
    #1;
    for (int i = 0; i < D; i++) f[i] = rand_sample(1);
    for (int i = 0; i < D; i++) g[i] = rand_sample(1);
    send_frame(f, 0);
    for (int i = 0; i < D - 1; i++) send_word(g[i], 0);
    bus.in_valid = 1'b1;
    bus.din = g[D-1];
    repeat (3) begin
      @(negedge clk);
      chk("bp_in_ready_stalled", bus.in_ready, 1'b0);
    end
    force_rdy = 1'b1;
    @(negedge clk);
    chk("bp_in_ready_release", bus.in_ready, 1'b1);
    force_rdy = 1'b0;
    @(posedge clk);
    #1;
    bus.in_valid = 1'b0;
    eb = model(g);
    exp_q.push_back(eb);
    @(negedge clk);
    chk("bp_continuous_valid", bus.out_valid, 1'b1);
    chk("bp_new_peak_val", bus.peak_val, eb.peak);
    chk("bp_new_frame_sum", bus.frame_sum, eb.sum);
    rdy_mode = 0;
    @(posedge clk);
    #1;
    drain();

    // Reset in the middle of a frame
    for (int i = 0; i < 5; i++) send_word(rand_sample(1), 0);
    reset = 1'b0;
    @(posedge clk);
    #1;
    @(negedge clk);
    check_reset_outputs("midreset");
    exp_q.delete();
    @(posedge clk);
    #1;
    reset = 1'b1;
    f = '{12'd0, 12'd0, 12'd0, 12'd0, 12'd0, 12'd0, 12'd0, 12'd7};
    send_frame(f, 0);

    // Randomized frames with random gaps and random backpressure
    rdy_mode = 1;
    for (int k = 0; k < 30; k++) begin
      int sel;
      sel = int'($urandom_range(0, 3));
      for (int i = 0; i < D; i++) f[i] = rand_sample(sel);
      send_frame(f, 30);
    end
    rdy_mode = 0;
    drain();
    @(negedge clk);
    chk("final_in_ready", bus.in_ready, 1'b1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

  initial begin
    #300000;
    $display("FAIL watchdog: got no completion by 300000, expected finish earlier");
    $fatal(1, "watchdog expired");
  end
endmodule

// File: doc/spec_peak_detect.md
SPEC_PEAK_DETECT -- requirements
Module: spec_peak_detect

Interface
REQ-001 Parameter: WIDTH, default 12, width of each input sample.
REQ-002 Parameter: DEPTH, default 8, words per frame; SHALL be a power of two, at least 2.
REQ-003 Parameter: THRESH, default 'h800, alarm threshold, unsigned, WIDTH bits.
REQ-004 Derived constant: IW = log2(DEPTH), index width (3 at default).
REQ-005 clk  input  1  single clock; all state changes on posedge clk.
REQ-006 reset  input  1  synchronous, active-low; sampled on posedge clk.
REQ-007 in_valid  input  1  din carries a sample this cycle.
REQ-008 in_ready  output  1  block accepts a sample this cycle.
REQ-009 din  input  WIDTH  unsigned accumulated-spectrum sample from the upstream accumulating FIFO stage, frame-ordered.
REQ-010 out_valid  output  1  result registers hold an unconsumed frame result.
REQ-011 out_ready  input  1  consumer takes the result this cycle.
REQ-012 peak_val  output  WIDTH  largest sample of the frame.
REQ-013 peak_idx  output  IW  position (0..DEPTH-1) of peak_val within the frame.
REQ-014 frame_sum  output  WIDTH+IW  sum of all DEPTH samples; never overflows.
REQ-015 alarm  output  1  peak_val >= THRESH; qualified by out_valid.

Function
REQ-016 A sample SHALL be accepted only when in_valid=1 and in_ready=1 in the same cycle.
REQ-017 States SHALL be IDLE (no partial frame) and SCAN (1..DEPTH-1 samples taken); word counter idx, IW bits.
REQ-018 IDLE, accept: running max <= din, max index <= 0, running sum <= zero-extended din, idx <= 1, go to SCAN.
REQ-019 SCAN, accept with idx<DEPTH-1: if din > running max (strict), max <= din and max index <= idx; sum += din; idx += 1.
REQ-020 Ties SHALL keep the earlier (lower) index.
REQ-021 SCAN, accept with idx=DEPTH-1: apply the same compare and sum to that word, load the result registers with the final values, set out_valid=1, set idx <= 0, go to IDLE; all in one edge.
REQ-022 Latency: out_valid SHALL rise on the clock edge that accepts the last word, so it is visible in the following cycle.
REQ-023 The result SHALL be consumed on a cycle with out_valid=1 and out_ready=1. out_valid SHALL then clear next edge, unless a new result loads on that same edge.
REQ-024 If a result is consumed and a new result loads on the same edge, out_valid SHALL stay 1 and the registers SHALL take the new values.
REQ-025 in_ready SHALL be 0 only when idx=DEPTH-1 and out_valid=1 and out_ready=0; otherwise 1. Scanning therefore overlaps an unconsumed result and no result is ever overwritten.
REQ-026 While out_valid=1 and out_ready=0, peak_val, peak_idx, frame_sum and alarm SHALL hold stable.
REQ-027 in_valid=0 cycles SHALL leave all state unchanged; gaps inside a frame are legal.
REQ-028 alarm SHALL be registered with the other results: 1 iff final peak >= THRESH, unsigned.
REQ-029 Running sum width SHALL be WIDTH+IW; all-ones input (DEPTH*(2^WIDTH-1)) SHALL be exact.
REQ-030 Result outputs SHALL be don't-care while out_valid=0, but SHALL read 0 after reset until the first load.

Reset
REQ-031 When reset=0 at a posedge, the block SHALL take: state IDLE, idx 0, running max/index/sum 0, out_valid 0, peak_val 0, peak_idx 0, frame_sum 0, alarm 0.
REQ-032 Reset SHALL take priority over any simultaneous accept or consume.
REQ-033 A partial frame at reset SHALL be discarded; the first accept after release is word 0 of a new frame.
REQ-034 in_ready SHALL be 1 during and immediately after reset.

Verification
REQ-035 Ramp frame 1,2,...,8 (default params), out_ready=1 -> one cycle after the 8th accept: out_valid=1, peak_val=8, peak_idx=7, frame_sum=36, alarm=0.
REQ-036 Ties: frame 5,9,3,9,0,9,1,2 -> peak_val=9, peak_idx=1, frame_sum=38.
REQ-037 Full scale: eight samples 'hFFF -> frame_sum='h7FF8, peak_idx=0, alarm=1. Also peak 'h800 -> alarm=1 and peak 'h7FF -> alarm=0.
REQ-038 Backpressure: out_ready=0, two back-to-back frames -> in_ready=0 holding the 2nd frame's 8th word and result 1 stable. Then out_ready=1 for one cycle -> result 1 consumed, word accepted, result 2 loaded next edge with out_valid continuously 1.
REQ-039 Reset mid-frame: reset=0 after 5 accepted words, then frame 0,0,0,0,0,0,0,7 -> outputs are 0 during reset, then peak_val=7, peak_idx=7, frame_sum=7.
REQ-040 Gaps: ramp frame with random in_valid=0 cycles inserted -> results identical to REQ-035, and out_valid pulses exactly once per frame.
